// File: rtl/vga_tile_renderer.sv
// VGA scan-out engine: ROWS x COLS grid of BPC-bit cells, each upscaled to CELL_W x CELL_H
// pixels through a live 12-bit palette, with a per-frame snapshot of the cell map.
module vga_tile_renderer #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int CLK_DIV  = 2,
  parameter int COLS     = 16,
  parameter int ROWS     = 12,
  parameter int CELL_W   = 40,
  parameter int CELL_H   = 40,
  parameter int BPC      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ROWS*COLS*BPC-1:0]   data,
  input  logic [(2**BPC)*12-1:0]     palette,
  output logic                       hSync,
  output logic                       vSync,
  output logic [3:0]                 r,
  output logic [3:0]                 g,
  output logic [3:0]                 b,
  output logic                       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int NCELL   = ROWS * COLS;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int IW = (NCELL > 1) ? $clog2(NCELL) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [XW-1:0] X_LAST    = XW'(CELL_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(CELL_H - 1);
  localparam logic [CW-1:0] COLS_C    = CW'(COLS);
  localparam logic [RW-1:0] ROWS_C    = RW'(ROWS);

  logic [DW-1:0] div;
  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic [XW-1:0] x_in_cell;
  logic [YW-1:0] y_in_cell;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          tick, h_wrap, v_wrap, frame_wrap, h_act, v_act, in_grid;
  logic [IW-1:0] cell_idx;
  logic [BPC-1:0] cell_val;
  logic [ROWS*COLS*BPC-1:0] snap;

  logic           act1, grid1, hs1, vs1;
  logic [BPC-1:0] cell1;
  logic [11:0]    pix;

  assign tick       = (div == DIV_LAST);
  assign h_wrap     = (h == H_LAST);
  assign v_wrap     = (v == V_LAST);
  assign frame_wrap = tick && h_wrap && v_wrap;
  assign h_next     = h_wrap ? '0 : h + 1'b1;
  assign v_next     = v_wrap ? '0 : v + 1'b1;
  assign h_act      = (h >= H_START_C) && (h < H_END_C);
  assign v_act      = (v >= V_START_C) && (v < V_END_C);
  assign in_grid    = (col < COLS_C) && (row < ROWS_C);
  assign cell_idx   = IW'(row) * IW'(COLS) + IW'(col);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      h <= h_next;
      if (h_wrap) v <= v_next;
    end
  end

  // Cell sub-counters are cleared one tick ahead so they are valid on the first active pixel;
  // col/row saturate at COLS/ROWS, which marks everything beyond the grid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_in_cell <= '0;
      col       <= '0;
      y_in_cell <= '0;
      row       <= '0;
    end else if (tick) begin
      if (h_next == H_START_C) begin
        x_in_cell <= '0;
        col       <= '0;
      end else if (h_act) begin
        if (x_in_cell == X_LAST) begin
          x_in_cell <= '0;
          if (col != COLS_C) col <= col + 1'b1;
        end else begin
          x_in_cell <= x_in_cell + 1'b1;
        end
      end
      if (h_wrap) begin
        if (v_next == V_START_C) begin
          y_in_cell <= '0;
          row       <= '0;
        end else if (v_act) begin
          if (y_in_cell == Y_LAST) begin
            y_in_cell <= '0;
            if (row != ROWS_C) row <= row + 1'b1;
          end else begin
            y_in_cell <= y_in_cell + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) snap <= data;
    end
  end

  always_comb begin
    cell_val = '0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (cell_idx == IW'(i)) cell_val = snap[i*BPC +: BPC];
    end
  end

  // Sync stage resets to the inactive level so the first low hSync lands on the 2nd tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act1  <= 1'b0;
      grid1 <= 1'b0;
      cell1 <= '0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else if (tick) begin
      act1  <= h_act && v_act;
      grid1 <= in_grid;
      cell1 <= in_grid ? cell_val : '0;
      hs1   <= (h >= H_SYNC_C);
      vs1   <= (v >= V_SYNC_C);
    end
  end

  always_comb begin
    pix = palette[11:0];
    for (int unsigned k = 0; k < 2**BPC; k++) begin
      if (grid1 && (cell1 == BPC'(k))) pix = palette[k*12 +: 12];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hSync     <= 1'b1;
      vSync     <= 1'b1;
      {r, g, b} <= '0;
    end else if (tick) begin
      hSync     <= hs1;
      vSync     <= vs1;
      {r, g, b} <= act1 ? pix : '0;
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a small timing/grid configuration, checked every clock
// against a frame/position arithmetic reference model.
module tb_vga_tile_renderer;

  localparam int H_SYNC = 3, H_BACK = 2, H_ACTIVE = 12, H_FRONT = 2;
  localparam int V_SYNC = 2, V_BACK = 1, V_ACTIVE = 9, V_FRONT = 1;
  localparam int CLK_DIV = 2, COLS = 5, ROWS = 4, CELL_W = 2, CELL_H = 2, BPC = 2;
  localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int FT = HT * VT;
  localparam int HS = H_SYNC + H_BACK;
  localparam int VS = V_SYNC + V_BACK;
  localparam int DW = ROWS * COLS * BPC;
  localparam int PW = (2**BPC) * 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data = '0;
  logic [PW-1:0] palette = '0;
  logic          hSync, vSync, frame_start;
  logic [3:0]    r, g, b;

  int tests = 0;
  int fails = 0;

  int            clk_cnt, tick_cnt, last_hfall, last_fs;
  logic          prev_hs;
  logic [DW-1:0] snaps [0:255];
  logic          exp_hs, exp_vs, exp_fs;
  logic [11:0]   exp_rgb;

  vga_tile_renderer #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
    .CLK_DIV(CLK_DIV), .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H), .BPC(BPC)
  ) dut (
    .clock(clock), .reset(reset), .data(data), .palette(palette),
    .hSync(hSync), .vSync(vSync), .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Colour of scan position p (ticks since reset) using the snapshot of its frame.
  function automatic logic [11:0] ref_pixel(input int p);
    int h, v, f, x, y, c, rw, k;
    logic [DW-1:0] s;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FT;
    if (h < HS || h >= HS + H_ACTIVE || v < VS || v >= VS + V_ACTIVE) return 12'h000;
    x  = h - HS;
    y  = v - VS;
    c  = x / CELL_W;
    rw = y / CELL_H;
    k  = 0;
    if (c < COLS && rw < ROWS) begin
      s = snaps[f];
      k = int'(s[(rw*COLS + c)*BPC +: BPC]);
    end
    return palette[k*12 +: 12];
  endfunction

  task automatic model_reset();
    clk_cnt    = 0;
    tick_cnt   = 0;
    snaps[0]   = '0;
    exp_hs     = 1'b1;
    exp_vs     = 1'b1;
    exp_fs     = 1'b0;
    exp_rgb    = '0;
    last_hfall = -1;
    last_fs    = -1;
    prev_hs    = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_hSync"}, 32'(hSync), 1);
    chk({tag, "_vSync"}, 32'(vSync), 1);
    chk({tag, "_rgb"}, 32'({r, g, b}), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  task automatic step();
    int p;
    @(posedge clock);
    clk_cnt++;
    exp_fs = 1'b0;
    if (clk_cnt % CLK_DIV == 0) begin
      tick_cnt++;
      if (tick_cnt % FT == 0) begin
        exp_fs = 1'b1;
        snaps[tick_cnt / FT] = data;
      end
      if (tick_cnt >= 2) begin
        p       = tick_cnt - 2;
        exp_hs  = ((p % HT) >= H_SYNC);
        exp_vs  = (((p / HT) % VT) >= V_SYNC);
        exp_rgb = ref_pixel(p);
      end
    end
    @(negedge clock);
    chk("hSync", 32'(hSync), 32'(exp_hs));
    chk("vSync", 32'(vSync), 32'(exp_vs));
    chk("rgb", 32'({r, g, b}), 32'(exp_rgb));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    if (prev_hs && !hSync) begin
      if (last_hfall >= 0) chk("line_period", clk_cnt - last_hfall, HT * CLK_DIV);
      else                 chk("first_hsync_low", clk_cnt, 2 * CLK_DIV);
      last_hfall = clk_cnt;
    end
    prev_hs = hSync;
    if (frame_start) begin
      if (last_fs >= 0) chk("frame_period", clk_cnt - last_fs, FT * CLK_DIV);
      last_fs = clk_cnt;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the DUT's current scan position lies in the middle of the active window.
  task automatic step_until_active();
    int h, v;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FT * CLK_DIV && !found; i++) begin
      step();
      h = tick_cnt % HT;
      v = (tick_cnt / HT) % VT;
      found = (h >= HS + 2) && (h < HS + H_ACTIVE - 2) && (v >= VS + 2) && (v < VS + V_ACTIVE - 2);
    end
    chk("active_reached", 32'(found), 1);
  endtask

  initial begin
    model_reset();
    data    = DW'({$urandom(), $urandom()});
    palette = PW'({$urandom(), $urandom()});
    repeat (3) @(negedge clock);
    chk_reset_values("in_reset");

    // Frame 0 renders entry 0 everywhere; frame 1 shows the random map.
    reset = 1'b1;
    run(2 * FT * CLK_DIV);

    // Corner cells on a primary-colour palette.
    data = '0;
    data[0 +: BPC] = 2'd1;
    data[(ROWS*COLS - 1)*BPC +: BPC] = 2'd3;
    palette = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
    run(2 * FT * CLK_DIV);

    // Entry 0 visible outside the grid.
    palette[11:0] = 12'h555;
    data = DW'({$urandom(), $urandom()});
    run(2 * FT * CLK_DIV);

    // Mid-active map change must wait for the next frame.
    step_until_active();
    data = ~data;
    run(FT * CLK_DIV + 20);

    // Random map/palette changes at random points in the frame.
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(600, 50));
      data = DW'({$urandom(), $urandom()});
      if ($urandom_range(1, 0) == 1) palette = PW'({$urandom(), $urandom()});
    end
    run(FT * CLK_DIV);

    // Asynchronous reset in mid-active, then restart with a zero snapshot.
    step_until_active();
    #2 reset = 1'b0;
    #1 chk_reset_values("async_reset");
    model_reset();
    data    = DW'({$urandom(), $urandom()}) | DW'(1);
    palette = PW'({$urandom(), $urandom()});
    palette[11:0] = 12'hA5C;
    repeat (3) begin
      @(negedge clock);
      chk_reset_values("held_reset");
    end
    reset = 1'b1;
    run(2 * FT * CLK_DIV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
